// File: rtl/dma_wr_reg_bank_mc.sv
// Multi-channel DMA write-register bank.
// Per-channel register windows plus FWFT buffer-address FIFOs.
module dma_wr_reg_bank_mc #(
  parameter int NUM_CH = 4,
  parameter int CH_W = 2,
  parameter int WIN_AW = 8,
  parameter int LINE_GAP_WIDTH = 16,
  parameter int CTRL_REG_WIDTH = 8,
  parameter int INT_WIDTH = 4,
  parameter int FIFO_DEPTH = 8,
  parameter logic [LINE_GAP_WIDTH-1:0] LINE_GAP_RST = 'h2000,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LVL_W = PW + 1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic mem_wr_valid,
  input  logic [31:0] mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  input  logic [3:0] mem_wr_strb,
  output logic glbl_int_en,
  output logic [NUM_CH*CTRL_REG_WIDTH-1:0] ctrl_reg,
  output logic [NUM_CH*LINE_GAP_WIDTH-1:0] line_gap,
  output logic [NUM_CH*INT_WIDTH-1:0] interrupt_en,
  output logic [NUM_CH*INT_WIDTH-1:0] interrupt_status_clr,
  input  logic [NUM_CH-1:0] buff_addr_rd_en,
  output logic [NUM_CH*32-1:0] buff_addr_dout,
  output logic [NUM_CH-1:0] buff_addr_empty,
  output logic [NUM_CH-1:0] buff_addr_full,
  output logic [NUM_CH*LVL_W-1:0] buff_addr_level,
  output logic [NUM_CH-1:0] buff_addr_ovf
);

  localparam logic [WIN_AW-1:0] OFF_CTRL = WIN_AW'(8'h00);
  localparam logic [WIN_AW-1:0] OFF_IEN  = WIN_AW'(8'h04);
  localparam logic [WIN_AW-1:0] OFF_IST  = WIN_AW'(8'h08);
  localparam logic [WIN_AW-1:0] OFF_LG   = WIN_AW'(8'h0C);
  localparam logic [WIN_AW-1:0] OFF_FIFO = WIN_AW'(8'h10);
  localparam logic [WIN_AW-1:0] OFF_GLBL = WIN_AW'(8'h14);

  logic [CH_W-1:0] w_ch;
  logic [WIN_AW-1:0] w_off;
  logic w_hit;
  logic w_unused;
  logic r_glbl;

  assign w_ch  = mem_wr_addr[WIN_AW+CH_W-1:WIN_AW];
  assign w_off = mem_wr_addr[WIN_AW-1:0];
  assign w_hit = mem_wr_valid &&
                 ({{(32-CH_W){1'b0}}, w_ch} < 32'(NUM_CH));
  assign w_unused = ^mem_wr_addr[31:WIN_AW+CH_W];
  assign glbl_int_en = r_glbl;

  // global interrupt enable lives only in channel 0's window
  always_ff @(posedge aclk) begin
    if (!aresetn)
      r_glbl <= 1'b0;
    else if (w_hit && w_ch == '0 && w_off == OFF_GLBL && mem_wr_strb[0])
      r_glbl <= mem_wr_data[0];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_sel;
    logic w_wr_ctrl;
    logic w_flush;
    logic w_push_req;
    logic [CTRL_REG_WIDTH-1:0] w_ctrl_nx;
    logic [INT_WIDTH-1:0] w_ien_nx;
    logic [LINE_GAP_WIDTH-1:0] w_lg_nx;
    logic [CTRL_REG_WIDTH-1:0] r_ctrl;
    logic [INT_WIDTH-1:0] r_ien;
    logic [INT_WIDTH-1:0] r_clr;
    logic [LINE_GAP_WIDTH-1:0] r_lg;

    logic [31:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [LVL_W-1:0] r_lvl;
    logic r_ovf;
    logic [31:0] r_dout;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;
    logic [PW-1:0] w_rp_nx;
    logic [LVL_W-1:0] w_lvl_nx;
    logic [31:0] w_head_nx;

    assign w_sel = w_hit && (w_ch == CH_W'(c));
    assign w_wr_ctrl = w_sel && w_off == OFF_CTRL;
    assign w_flush = w_wr_ctrl && mem_wr_strb[0] && mem_wr_data[1];
    assign w_push_req = w_sel && w_off == OFF_FIFO &&
                        mem_wr_strb == 4'hF;

    // byte-strobed merge; ctrl pulse bits never inherit old state
    always_comb begin
      w_ctrl_nx = '0;
      w_ien_nx = r_ien;
      w_lg_nx = r_lg;
      w_ctrl_nx[0] = mem_wr_strb[0] ? mem_wr_data[0] : r_ctrl[0];
      for (int i = 1; i < CTRL_REG_WIDTH; i++)
        w_ctrl_nx[i] = mem_wr_strb[i/8] & mem_wr_data[i];
      for (int i = 0; i < INT_WIDTH; i++)
        if (mem_wr_strb[i/8]) w_ien_nx[i] = mem_wr_data[i];
      for (int i = 0; i < LINE_GAP_WIDTH; i++)
        if (mem_wr_strb[i/8]) w_lg_nx[i] = mem_wr_data[i];
    end

    // channel registers; ctrl upper bits self-clear after one cycle
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        r_ctrl <= '0;
        r_ien <= '0;
        r_clr <= '0;
        r_lg <= LINE_GAP_RST;
      end else begin
        if (w_wr_ctrl)
          r_ctrl <= w_ctrl_nx;
        else
          r_ctrl <= {{(CTRL_REG_WIDTH-1){1'b0}}, r_ctrl[0]};
        if (w_sel && w_off == OFF_IEN) r_ien <= w_ien_nx;
        if (w_sel && w_off == OFF_LG) r_lg <= w_lg_nx;
        r_clr <= (w_sel && w_off == OFF_IST && mem_wr_strb[0]) ?
                 mem_wr_data[INT_WIDTH-1:0] : '0;
      end
    end

    assign w_empty = r_lvl == '0;
    assign w_full = r_lvl == LVL_W'(FIFO_DEPTH);
    assign w_pop = buff_addr_rd_en[c] && !w_empty;
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_ovf_set = w_push_req && w_full && !w_pop;
    assign w_rp_nx = w_pop ? r_rp + 1'b1 : r_rp;
    // a push landing on the new head slot bypasses the array
    assign w_head_nx = (w_push && r_wp == w_rp_nx) ?
                       mem_wr_data : r_mem[w_rp_nx];

    // next occupancy from push/pop pair
    always_comb begin
      w_lvl_nx = r_lvl;
      unique case ({w_push, w_pop})
        2'b10: w_lvl_nx = r_lvl + LVL_W'(1);
        2'b01: w_lvl_nx = r_lvl - LVL_W'(1);
        default: w_lvl_nx = r_lvl;
      endcase
    end

    // fifo storage, no reset needed
    always_ff @(posedge aclk) begin
      if (w_push) r_mem[r_wp] <= mem_wr_data;
    end

    // fifo pointers, level, sticky overflow and registered head word
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        r_wp <= '0;
        r_rp <= '0;
        r_lvl <= '0;
        r_ovf <= 1'b0;
        r_dout <= '0;
      end else if (w_flush) begin
        r_wp <= '0;
        r_rp <= '0;
        r_lvl <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_push) r_wp <= r_wp + 1'b1;
        r_rp <= w_rp_nx;
        r_lvl <= w_lvl_nx;
        if (w_ovf_set) r_ovf <= 1'b1;
        if (w_lvl_nx != '0) r_dout <= w_head_nx;
      end
    end

    assign ctrl_reg[c*CTRL_REG_WIDTH +: CTRL_REG_WIDTH] = r_ctrl;
    assign line_gap[c*LINE_GAP_WIDTH +: LINE_GAP_WIDTH] = r_lg;
    assign interrupt_en[c*INT_WIDTH +: INT_WIDTH] = r_ien;
    assign interrupt_status_clr[c*INT_WIDTH +: INT_WIDTH] = r_clr;
    assign buff_addr_dout[c*32 +: 32] = r_dout;
    assign buff_addr_empty[c] = w_empty;
    assign buff_addr_full[c] = w_full;
    assign buff_addr_level[c*LVL_W +: LVL_W] = r_lvl;
    assign buff_addr_ovf[c] = r_ovf;
  end

endmodule

// File: tb/tb_dma_wr_reg_bank_mc.sv
// Testbench for dma_wr_reg_bank_mc.
// Directed vector table plus multi-cycle FIFO/reset sequences.
module tb_dma_wr_reg_bank_mc;

  localparam int F_LG = 0;
  localparam int F_IEN = 1;
  localparam int F_CTRL = 2;
  localparam int F_GLBL = 3;
  localparam int F_CLR = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    int fld;
    int ch;
    logic [31:0] exp;
  } vec_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic mem_wr_valid = 1'b0;
  logic [31:0] mem_wr_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic [3:0] mem_wr_strb = '0;
  logic [3:0] rd_en = '0;

  logic glbl_int_en;
  logic [31:0] ctrl_reg;
  logic [63:0] line_gap;
  logic [15:0] interrupt_en;
  logic [15:0] interrupt_status_clr;
  logic [127:0] buff_addr_dout;
  logic [3:0] buff_addr_empty;
  logic [3:0] buff_addr_full;
  logic [15:0] buff_addr_level;
  logic [3:0] buff_addr_ovf;

  logic t_glbl;
  logic [23:0] t_ctrl;
  logic [47:0] t_lg;
  logic [11:0] t_ien;
  logic [11:0] t_clr;
  logic [95:0] t_dout;
  logic [2:0] t_empty;
  logic [2:0] t_full;
  logic [11:0] t_level;
  logic [2:0] t_ovf;

  int n_run = 0;
  int n_fail = 0;
  vec_t vt[16];

  always #5 aclk = ~aclk;

  dma_wr_reg_bank_mc u_dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .mem_wr_valid(mem_wr_valid),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb),
    .glbl_int_en(glbl_int_en),
    .ctrl_reg(ctrl_reg),
    .line_gap(line_gap),
    .interrupt_en(interrupt_en),
    .interrupt_status_clr(interrupt_status_clr),
    .buff_addr_rd_en(rd_en),
    .buff_addr_dout(buff_addr_dout),
    .buff_addr_empty(buff_addr_empty),
    .buff_addr_full(buff_addr_full),
    .buff_addr_level(buff_addr_level),
    .buff_addr_ovf(buff_addr_ovf)
  );

  // three-channel instance: channel code 3 is out of range here
  dma_wr_reg_bank_mc #(.NUM_CH(3), .CH_W(2)) u_dut3 (
    .aclk(aclk),
    .aresetn(aresetn),
    .mem_wr_valid(mem_wr_valid),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb),
    .glbl_int_en(t_glbl),
    .ctrl_reg(t_ctrl),
    .line_gap(t_lg),
    .interrupt_en(t_ien),
    .interrupt_status_clr(t_clr),
    .buff_addr_rd_en(rd_en[2:0]),
    .buff_addr_dout(t_dout),
    .buff_addr_empty(t_empty),
    .buff_addr_full(t_full),
    .buff_addr_level(t_level),
    .buff_addr_ovf(t_ovf)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wrpop(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [3:0] m);
    mem_wr_valid = 1'b1;
    mem_wr_addr = a;
    mem_wr_data = d;
    mem_wr_strb = s;
    rd_en = m;
    tick();
    mem_wr_valid = 1'b0;
    mem_wr_strb = '0;
    rd_en = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    wrpop(a, d, s, 4'h0);
  endtask

  task automatic pop(input int c);
    rd_en = '0;
    rd_en[c] = 1'b1;
    tick();
    rd_en = '0;
  endtask

  function automatic logic [31:0] fld(input int f, input int c);
    case (f)
      F_LG: return 32'(line_gap[c*16 +: 16]);
      F_IEN: return 32'(interrupt_en[c*4 +: 4]);
      F_CTRL: return 32'(ctrl_reg[c*8 +: 8]);
      F_GLBL: return 32'(glbl_int_en);
      default: return 32'(interrupt_status_clr[c*4 +: 4]);
    endcase
  endfunction

  function automatic logic [31:0] dout(input int c);
    return buff_addr_dout[c*32 +: 32];
  endfunction

  function automatic logic [3:0] lvl(input int c);
    return buff_addr_level[c*4 +: 4];
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_lg"}, line_gap, 64'h2000_2000_2000_2000);
    chk({tag, "_ctrl"}, ctrl_reg, 0);
    chk({tag, "_ien"}, interrupt_en, 0);
    chk({tag, "_clr"}, interrupt_status_clr, 0);
    chk({tag, "_glbl"}, glbl_int_en, 0);
    chk({tag, "_empty"}, buff_addr_empty, 4'hF);
    chk({tag, "_full"}, buff_addr_full, 0);
    chk({tag, "_level"}, buff_addr_level, 0);
    chk({tag, "_ovf"}, buff_addr_ovf, 0);
    chk({tag, "_dout_lo"}, buff_addr_dout[63:0], 0);
    chk({tag, "_dout_hi"}, buff_addr_dout[127:64], 0);
  endtask

  initial begin
    vt[0]  = '{32'h0000_020C, 32'h1234_5678, 4'h1, F_LG, 2, 32'h2078};
    vt[1]  = '{32'h0000_020C, 32'hAABB_CCDD, 4'h2, F_LG, 2, 32'hCC78};
    vt[2]  = '{32'h0000_010C, 32'hFFFF_1234, 4'hF, F_LG, 1, 32'h1234};
    vt[3]  = '{32'h0000_0004, 32'hFFFF_FFF5, 4'h1, F_IEN, 0, 32'h5};
    vt[4]  = '{32'h0000_0304, 32'h0000_000A, 4'h2, F_IEN, 3, 32'h0};
    vt[5]  = '{32'h0000_0014, 32'h0000_0001, 4'h1, F_GLBL, 0, 32'h1};
    vt[6]  = '{32'h0000_0114, 32'h0000_0000, 4'h1, F_GLBL, 0, 32'h1};
    vt[7]  = '{32'h0000_0014, 32'h0000_0000, 4'h0, F_GLBL, 0, 32'h1};
    vt[8]  = '{32'h0000_0308, 32'h0000_0009, 4'h1, F_CLR, 3, 32'h9};
    vt[9]  = '{32'h0000_0308, 32'h0000_0006, 4'h2, F_CLR, 3, 32'h0};
    vt[10] = '{32'hFFFF_F30C, 32'h0000_0055, 4'h1, F_LG, 3, 32'h2055};
    vt[11] = '{32'h0000_0318, 32'hFFFF_FFFF, 4'hF, F_LG, 3, 32'h2055};
    vt[12] = '{32'h0000_0200, 32'h0000_0001, 4'h1, F_CTRL, 2, 32'h01};
    vt[13] = '{32'h0000_0100, 32'h0000_0004, 4'h1, F_CTRL, 1, 32'h04};
    vt[14] = '{32'h0000_0000, 32'h0000_00FF, 4'h0, F_CTRL, 0, 32'h00};
    vt[15] = '{32'h0000_0104, 32'h0000_00F0, 4'h1, F_IEN, 1, 32'h0};

    repeat (2) tick();
    chk_reset("rst");
    aresetn = 1'b1;
    tick();
    chk_reset("idle");

    for (int i = 0; i < 16; i++) begin
      wr(vt[i].addr, vt[i].data, vt[i].strb);
      chk($sformatf("vec%0d", i), fld(vt[i].fld, vt[i].ch), vt[i].exp);
    end
    chk("lg_others", {line_gap[63:48], line_gap[15:0]},
        32'h2055_2000);

    for (int k = 0; k < 3; k++) wr(32'h110, 32'h11 + k, 4'hF);
    chk("ch1_lvl3", lvl(1), 3);
    wr(32'h100, 32'h07, 4'h1);
    chk("ch1_ctrl_pulse", fld(F_CTRL, 1), 32'h07);
    chk("ch1_flush_lvl", lvl(1), 0);
    chk("ch1_flush_empty", buff_addr_empty[1], 1);
    chk("ch2_ctrl_quiet", fld(F_CTRL, 2), 32'h01);
    tick();
    chk("ch1_ctrl_after", fld(F_CTRL, 1), 32'h01);

    wr(32'h010, 32'hDEAD, 4'h7);
    chk("ch0_partial_push", lvl(0), 0);
    for (int k = 0; k < 8; k++) wr(32'h010, 32'hA0 + k, 4'hF);
    chk("ch0_full", buff_addr_full[0], 1);
    chk("ch0_ovf_pre", buff_addr_ovf[0], 0);
    wr(32'h010, 32'hA8, 4'hF);
    chk("ch0_ovf", buff_addr_ovf[0], 1);
    chk("ch0_lvl8", lvl(0), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ch0_pop%0d", k), dout(0), 32'hA0 + k);
      pop(0);
    end
    chk("ch0_empty", buff_addr_empty[0], 1);
    chk("ch0_ovf_sticky", buff_addr_ovf[0], 1);
    pop(0);
    chk("ch0_pop_empty_dout", dout(0), 32'hA7);
    chk("ch0_pop_empty_lvl", lvl(0), 0);
    wrpop(32'h010, 32'hC0, 4'hF, 4'b0001);
    chk("ch0_pp_empty_lvl", lvl(0), 1);
    chk("ch0_pp_empty_dout", dout(0), 32'hC0);
    wrpop(32'h010, 32'hC1, 4'hF, 4'b0001);
    chk("ch0_pp_one_lvl", lvl(0), 1);
    chk("ch0_pp_one_dout", dout(0), 32'hC1);
    wr(32'h010, 32'hD0, 4'hF);
    wr(32'h010, 32'hD1, 4'hF);
    chk("ch0_lvl3", lvl(0), 3);
    wrpop(32'h000, 32'h02, 4'h1, 4'b0001);
    chk("ch0_flushpop_lvl", lvl(0), 0);
    chk("ch0_flushpop_ovf", buff_addr_ovf[0], 0);
    chk("ch0_flushpop_empty", buff_addr_empty[0], 1);
    chk("ch0_flush_ctrl", fld(F_CTRL, 0), 32'h02);

    for (int k = 0; k < 8; k++) wr(32'h310, 32'h30 + k, 4'hF);
    chk("ch3_full", buff_addr_full[3], 1);
    wrpop(32'h310, 32'hBEEF, 4'hF, 4'b1000);
    chk("ch3_pp_lvl", lvl(3), 8);
    chk("ch3_pp_ovf", buff_addr_ovf[3], 0);
    chk("ch3_pp_full", buff_addr_full[3], 1);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("ch3_pop%0d", k), dout(3), 32'h31 + k);
      pop(3);
    end
    chk("ch3_beef", dout(3), 32'hBEEF);

    wr(32'h008, 32'hF, 4'h1);
    chk("clr_pulse", interrupt_status_clr, 16'h000F);
    tick();
    chk("clr_after", interrupt_status_clr, 16'h0000);

    wr(32'h210, 32'h77, 4'hF);
    wr(32'h014, 32'h1, 4'h1);
    aresetn = 1'b0;
    wrpop(32'h00C, 32'hFFFF, 4'hF, 4'hF);
    aresetn = 1'b1;
    chk_reset("midrst");

    wr(32'h300, 32'hFF, 4'hF);
    chk("oor_ctrl", t_ctrl, 0);
    wr(32'h30C, 32'h1234, 4'hF);
    wr(32'h304, 32'hF, 4'hF);
    wr(32'h310, 32'h99, 4'hF);
    chk("oor_lg", t_lg, 48'h2000_2000_2000);
    chk("oor_ien", t_ien, 0);
    chk("oor_empty", t_empty, 3'b111);
    chk("oor_level", t_level, 0);
    wr(32'h20C, 32'h0042, 4'h1);
    chk("dut3_ch2_lg", t_lg[47:32], 16'h2042);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
